starfield_mixer: RTL

STARFIELD_MIXER -- requirements
Module: starfield_mixer

---
 rtl/starfield_mixer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/starfield_mixer.sv
// rtl/starfield_mixer.sv - three-layer starfield priority mixer with tint and twinkle
// Two-stage pipeline: stage 1 selects the visible layer, stage 2 scales/tints the colour.
module starfield_mixer #(
  parameter int SHIFT0      = 2,
  parameter int SHIFT1      = 1,
  parameter int SHIFT2      = 0,
  parameter int TWINKLE_DIV = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       frame_start,
  input  logic       de,
  input  logic       sf0_on,
  input  logic       sf1_on,
  input  logic       sf2_on,
  input  logic [7:0] sf0_star,
  input  logic [7:0] sf1_star,
  input  logic [7:0] sf2_star,
  output logic [7:0] out_r,
  output logic [7:0] out_g,
  output logic [7:0] out_b,
  output logic       out_de
);

  localparam logic [7:0] FCNT_LAST = 8'(TWINKLE_DIV - 1);

  logic [7:0] fcnt;
  logic [2:0] phase;

  logic       sel_hit;
  logic [1:0] sel_layer;
  logic [7:0] sel_star;
  logic       sel_tw;

  logic       s1_de;
  logic       s1_hit;
  logic [1:0] s1_layer;
  logic [7:0] s1_star;
  logic       s1_tw;

  logic [7:0] lvl_raw;
  logic [7:0] lvl;
  logic [7:0] tint_r;
  logic [7:0] tint_g;
  logic [7:0] tint_b;

  always_comb begin
    sel_hit   = 1'b0;
    sel_layer = 2'd0;
    sel_star  = 8'd0;
    if (sf2_on) begin
      sel_hit   = 1'b1;
      sel_layer = 2'd2;
      sel_star  = sf2_star;
    end else if (sf1_on) begin
      sel_hit   = 1'b1;
      sel_layer = 2'd1;
      sel_star  = sf1_star;
    end else if (sf0_on) begin
      sel_hit   = 1'b1;
      sel_layer = 2'd0;
      sel_star  = sf0_star;
    end
  end

  // Twinkle is decided here, against the phase held before this edge, so the
  // frame_start pixel still sees the previous phase.
  assign sel_tw = sel_hit && (sel_star[2:0] == phase);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt  <= 8'd0;
      phase <= 3'd0;
    end else if (en && frame_start) begin
      if (fcnt == FCNT_LAST) begin
        fcnt  <= 8'd0;
        phase <= phase + 3'd1;
      end else begin
        fcnt <= fcnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_de    <= 1'b0;
      s1_hit   <= 1'b0;
      s1_layer <= 2'd0;
      s1_star  <= 8'd0;
      s1_tw    <= 1'b0;
    end else if (en) begin
      s1_de    <= de;
      s1_hit   <= sel_hit;
      s1_layer <= sel_layer;
      s1_star  <= sel_star;
      s1_tw    <= sel_tw;
    end
  end

  always_comb begin
    lvl_raw = 8'd0;
    if (s1_hit) begin
      case (s1_layer)
        2'd2:    lvl_raw = s1_star >> SHIFT2;
        2'd1:    lvl_raw = s1_star >> SHIFT1;
        default: lvl_raw = s1_star >> SHIFT0;
      endcase
    end
    lvl = s1_tw ? (lvl_raw >> 1) : lvl_raw;
  end

  // Farther layers lose red first, giving a blue cast with depth.
  always_comb begin
    tint_r = lvl;
    tint_g = lvl;
    tint_b = lvl;
    case (s1_layer)
      2'd1: tint_r = lvl >> 1;
      2'd0: begin
        tint_r = lvl >> 1;
        tint_g = lvl >> 1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_r  <= 8'd0;
      out_g  <= 8'd0;
      out_b  <= 8'd0;
      out_de <= 1'b0;
    end else if (en) begin
      out_r  <= s1_de ? tint_r : 8'd0;
      out_g  <= s1_de ? tint_g : 8'd0;
      out_b  <= s1_de ? tint_b : 8'd0;
      out_de <= s1_de;
    end
  end

endmodule
